// File: rtl/sh_pkg.sv
// +----------------------------------------------------------------------------+
// | sh_pkg : constants and state encodings shared by the sample/hold RX path   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sh_pkg;

    localparam int PACKET_SIZE    = 24;
    localparam int PREAMBLE_SIZE  = 8;
    // 1 ms between sample pulses at 10 MHz, shared with the sync FSM.
    localparam int PULSE_INTERVAL = 9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } sh_state_t;

endpackage

`default_nettype wire

// File: rtl/sh_bit_sync.sv
// +----------------------------------------------------------------------------+
// | sh_bit_sync : two-flop synchronizer with rising-edge detect on the output  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sh_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_d;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_sync_d;

endmodule

`default_nettype wire

// File: rtl/sh_rx_deserializer.sv
// +----------------------------------------------------------------------------+
// | sh_rx_deserializer : shifts sampled comparator bits into PACKET_SIZE words |
// | Optional macro SH_RX_PARITY_EN adds even-parity check and parity_ok. Rev 1 |
// +----------------------------------------------------------------------------+
`default_nettype none

module sh_rx_deserializer #(
    parameter int PACKET_SIZE = sh_pkg::PACKET_SIZE,
    parameter int SKIP_PULSES = 1,
    parameter int MSB_FIRST   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RX,
    input  logic                   sh_en,
    input  logic                   fsm_rst,
    input  logic                   sh_en_done,
    input  logic                   data_in,
    output logic [PACKET_SIZE-1:0] pkt_data,
    output logic                   pkt_valid,
    output logic                   pkt_err,
    output logic [4:0]             bit_cnt
`ifdef SH_RX_PARITY_EN
    ,
    output logic                   parity_ok
`endif
);

    import sh_pkg::*;

    localparam int             SKW          = (SKIP_PULSES < 1) ? 1 : $clog2(SKIP_PULSES + 1);
    localparam logic [SKW-1:0] c_skip_last  = SKW'(SKIP_PULSES);
    localparam logic [4:0]     c_cnt_last   = 5'(PACKET_SIZE - 1);
    localparam logic [4:0]     c_cnt_full   = 5'(PACKET_SIZE);

    sh_state_t              r_state;
    logic                   r_sh_en_prev;
    logic [SKW-1:0]         r_skip;
    logic [PACKET_SIZE-1:0] r_shift;
    logic [PACKET_SIZE-1:0] w_shift_next;
    logic                   w_data_s;
    logic                   w_data_rise_unused;
    logic                   w_done_sync_unused;
    logic                   w_done_rise;
    logic                   w_stb;
    logic                   w_abort;
    logic                   w_partial;

    sh_bit_sync u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (data_in),
        .o_sync (w_data_s),
        .o_rise (w_data_rise_unused)
    );

    sh_bit_sync u_done_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (sh_en_done),
        .o_sync (w_done_sync_unused),
        .o_rise (w_done_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_en_prev <= 1'b0;
        end else begin
            r_sh_en_prev <= sh_en;
        end
    end

    // A held-high sh_en yields a single strobe.
    assign w_stb     = sh_en & ~r_sh_en_prev;
    assign w_abort   = ((r_state == ST_ARMED) || (r_state == ST_SHIFT)) && (!RX || w_done_rise);
    assign w_partial = (bit_cnt != 5'd0) && (bit_cnt < c_cnt_full);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[PACKET_SIZE-2:0], w_data_s};
        end else begin : g_lsb_first
            assign w_shift_next = {w_data_s, r_shift[PACKET_SIZE-1:1]};
        end
    endgenerate

`ifdef SH_RX_PARITY_EN
    logic w_parity_ok;
    // Last captured bit makes the whole word even, so the XOR of all bits is 0.
    assign w_parity_ok = ~(^r_shift);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_skip    <= '0;
            r_shift   <= '0;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            pkt_err   <= 1'b0;
            bit_cnt   <= 5'd0;
`ifdef SH_RX_PARITY_EN
            parity_ok <= 1'b0;
`endif
        end else begin
            pkt_valid <= 1'b0;
            pkt_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (RX && fsm_rst) begin
                        r_state <= ST_ARMED;
                        r_skip  <= '0;
                        r_shift <= '0;
                        bit_cnt <= 5'd0;
                    end
                end
                ST_ARMED: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        pkt_err <= w_partial;
                    end else if (fsm_rst) begin
                        r_skip  <= '0;
                        r_shift <= '0;
                        bit_cnt <= 5'd0;
                    end else if (w_stb) begin
                        if (r_skip == c_skip_last) begin
                            r_shift <= w_shift_next;
                            bit_cnt <= 5'd1;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_skip <= r_skip + 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    // Abort beats a fresh preamble edge, which beats a strobe.
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        pkt_err <= w_partial;
                    end else if (fsm_rst) begin
                        r_state <= ST_ARMED;
                        r_skip  <= '0;
                        r_shift <= '0;
                        bit_cnt <= 5'd0;
                    end else if (w_stb) begin
                        r_shift <= w_shift_next;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == c_cnt_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    pkt_data  <= r_shift;
                    pkt_valid <= 1'b1;
                    r_state   <= ST_IDLE;
`ifdef SH_RX_PARITY_EN
                    parity_ok <= w_parity_ok;
                    pkt_err   <= ~w_parity_ok;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sh_rx_deserializer.sv
// +----------------------------------------------------------------------------+
// | tb_sh_rx_deserializer : randomized scoreboard bench for sh_rx_deserializer |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sh_rx_deserializer;

    localparam int PS   = 24;
    localparam int SKIP = 1;
    localparam int MSB  = 1;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          RX         = 1'b0;
    logic          sh_en      = 1'b0;
    logic          fsm_rst    = 1'b0;
    logic          sh_en_done = 1'b0;
    logic          data_in    = 1'b0;
    logic [PS-1:0] pkt_data;
    logic          pkt_valid;
    logic          pkt_err;
    logic [4:0]    bit_cnt;
`ifdef SH_RX_PARITY_EN
    logic          parity_ok;
`endif

    sh_rx_deserializer #(
        .PACKET_SIZE (PS),
        .SKIP_PULSES (SKIP),
        .MSB_FIRST   (MSB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .sh_en      (sh_en),
        .fsm_rst    (fsm_rst),
        .sh_en_done (sh_en_done),
        .data_in    (data_in),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_err    (pkt_err),
        .bit_cnt    (bit_cnt)
`ifdef SH_RX_PARITY_EN
        ,
        .parity_ok  (parity_ok)
`endif
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          is_v;
        logic          is_e;
        logic [PS-1:0] data;
        logic          pok;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          m;
    int            n_vec = 0;
    int            n_err = 0;
    logic [PS-1:0] last_payload = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Order in which a payload's bits go out on the wire.
    function automatic logic wire_bit(input logic [PS-1:0] p, input int i);
        return (MSB != 0) ? p[PS-1-i] : p[i];
    endfunction

    function automatic exp_t good_exp(input logic [PS-1:0] p, input int c);
        exp_t e;
        e.is_v = 1'b1;
        e.data = p;
        e.cyc  = c;
`ifdef SH_RX_PARITY_EN
        e.pok  = ~(^p);
        e.is_e = ^p;
`else
        e.pok  = 1'b0;
        e.is_e = 1'b0;
`endif
        return e;
    endfunction

    task automatic pulse_rise(input logic b);
        data_in = b;
        tick(4);
        sh_en = 1'b1;
    endtask

    task automatic pulse_fall(input int len, input int gap);
        tick(len);
        sh_en = 1'b0;
        tick(gap);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_output: %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic arm();
        fsm_rst = 1'b1;
        tick(1);
        fsm_rst = 1'b0;
        tick(1);
        chk("bit_cnt_on_arm", 32'(bit_cnt), 32'd0);
    endtask

    task automatic send_skips(input int gap);
        for (int s = 0; s < SKIP; s++) begin
            pulse_rise(1'($urandom_range(0, 1)));
            pulse_fall(1, gap);
        end
    endtask

    task automatic full_frame(input logic [PS-1:0] p, input int gap, input bit do_arm, input bit extra);
        if (do_arm) arm();
        send_skips(gap);
        for (int i = 0; i < PS; i++) begin
            pulse_rise(wire_bit(p, i));
            if (i == PS - 1) sb.push_back(good_exp(p, cyc + 2));
            pulse_fall($urandom_range(1, 3), gap);
        end
        if (extra) begin
            pulse_rise(1'($urandom_range(0, 1)));
            pulse_fall(1, gap);
        end
        drain();
        chk("bit_cnt_hold", 32'(bit_cnt), 32'(PS));
        last_payload = p;
    endtask

    task automatic abort_frame(input logic [PS-1:0] p, input int nbits, input bit by_done);
        exp_t e;
        arm();
        send_skips(2);
        for (int i = 0; i < nbits; i++) begin
            pulse_rise(wire_bit(p, i));
            pulse_fall(3, 2);
        end
        chk("bit_cnt_partial", 32'(bit_cnt), 32'(nbits));
        e.is_v = 1'b0;
        e.is_e = 1'b1;
        e.data = '0;
        e.pok  = 1'b0;
        e.cyc  = -1;
        if (by_done) begin
            sh_en_done = 1'b1;
            if (nbits > 0) sb.push_back(e);
            tick(6);
            sh_en_done = 1'b0;
        end else begin
            RX = 1'b0;
            e.cyc = cyc + 1;
            if (nbits > 0) sb.push_back(e);
            tick(3);
            RX = 1'b1;
        end
        tick(2);
        drain();
        chk("bit_cnt_frozen", 32'(bit_cnt), 32'(nbits));
        chk("pkt_data_kept", 32'(pkt_data), 32'(last_payload));
    endtask

    function automatic logic [PS-1:0] rand_payload();
        logic [PS-1:0] p;
        p = PS'($urandom());
`ifdef SH_RX_PARITY_EN
        p[0] = (^p[PS-1:1]) ^ ($urandom_range(0, 3) == 0);
`endif
        return p;
    endfunction

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst && (pkt_valid || pkt_err)) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: valid=%0b err=%0b data=0x%0h, expected none",
                                 pkt_valid, pkt_err, pkt_data);
                    end else begin
                        m = sb.pop_front();
                        chk("pkt_valid", 32'(pkt_valid), 32'(m.is_v));
                        chk("pkt_err", 32'(pkt_err), 32'(m.is_e));
                        if (m.is_v) begin
                            chk("pkt_data", 32'(pkt_data), 32'(m.data));
`ifdef SH_RX_PARITY_EN
                            chk("parity_ok", 32'(parity_ok), 32'(m.pok));
`endif
                        end
                        if (m.cyc >= 0) chk("latency_cycle", 32'(cyc), 32'(m.cyc));
                    end
                end
            end
        join_none

        tick(3);
        chk("reset_pkt_data", 32'(pkt_data), 32'd0);
        chk("reset_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("reset_pkt_err", 32'(pkt_err), 32'd0);
        chk("reset_bit_cnt", 32'(bit_cnt), 32'd0);
        rst = 1'b1;
        RX  = 1'b1;
        tick(2);

        // Nominal frame at the real 1 ms pulse spacing, plus a 26th pulse.
        full_frame(24'hA5C33C, 995, 1'b1, 1'b1);

        // Mode abort after 10 held-high strobes.
        abort_frame(24'h5A5A5A, 10, 1'b0);

        // Re-preamble coinciding with a strobe at bit 7, then a complete frame.
        arm();
        send_skips(2);
        for (int i = 0; i < 7; i++) begin
            pulse_rise(wire_bit(24'hFFFFFF, i));
            pulse_fall(1, 2);
        end
        data_in = 1'b1;
        tick(4);
        fsm_rst = 1'b1;
        sh_en   = 1'b1;
        tick(1);
        fsm_rst = 1'b0;
        tick(1);
        sh_en = 1'b0;
        tick(2);
        chk("bit_cnt_repreamble", 32'(bit_cnt), 32'd0);
        full_frame(24'h3C96E1, 2, 1'b0, 1'b0);

        // Randomized mix of complete frames and aborts.
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 2))
                0:       full_frame(rand_payload(), $urandom_range(1, 6), 1'b1, 1'($urandom_range(0, 1)));
                1:       abort_frame(rand_payload(), $urandom_range(0, PS - 1), 1'b0);
                default: abort_frame(rand_payload(), $urandom_range(0, PS - 1), 1'b1);
            endcase
        end

        // Asynchronous reset in the middle of a frame.
        arm();
        send_skips(2);
        for (int i = 0; i < 12; i++) begin
            pulse_rise(1'($urandom_range(0, 1)));
            pulse_fall(1, 2);
        end
        #20 rst = 1'b0;
        #1;
        chk("async_pkt_data", 32'(pkt_data), 32'd0);
        chk("async_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("async_pkt_err", 32'(pkt_err), 32'd0);
        chk("async_bit_cnt", 32'(bit_cnt), 32'd0);
        last_payload = '0;
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < PS + 1; i++) begin
            pulse_rise(1'($urandom_range(0, 1)));
            pulse_fall(1, 2);
        end
        drain();
        chk("bit_cnt_after_reset", 32'(bit_cnt), 32'd0);

`ifdef SH_RX_PARITY_EN
        full_frame(24'h000003, 2, 1'b1, 1'b0);
        full_frame(24'h000001, 2, 1'b1, 1'b0);
`endif

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sh_rx_deserializer.md
Name: sh_rx_deserializer

Overview:
- Sits directly downstream of the sample/hold sync FSM on the receive path.
- Each sh_en pulse in RX mode samples the synchronized comparator data bit and shifts it into a packet register.
- After PACKET_SIZE bits it presents a one-cycle-valid payload to the packet/register layer.
- A frame is (re)armed by the sync FSM's fsm_rst and sh_en_done signals.

Parameters:
- PACKET_SIZE, 24, data bits per packet (shift register width)
- SKIP_PULSES, 1, leading sh_en pulses per frame discarded before capture (the half-interval alignment pulse)
- MSB_FIRST, 1, 1 = first captured bit lands in pkt_data[PACKET_SIZE-1]; 0 = lands in pkt_data[0]

Ports:
- clk  in  1  system clock (10 MHz)
- rst  in  1  asynchronous active-low reset
- RX  in  1  1 = receive mode, 0 = transmit mode
- sh_en  in  1  sample strobe from sync FSM (registered, nominally 1-cycle pulse)
- fsm_rst  in  1  preamble-edge/timeout pulse from sync FSM
- sh_en_done  in  1  1 = sync FSM idle/no generation active
- data_in  in  1  asynchronous comparator output
- pkt_data  out  PACKET_SIZE  captured payload, stable until next pkt_valid
- pkt_valid  out  1  one-cycle strobe, payload complete
- pkt_err  out  1  one-cycle strobe, frame aborted with a partial packet
- bit_cnt  out  5  bits captured in current frame

Behaviour:
- Reset (rst=0, async): state=IDLE; pkt_data=0, pkt_valid=0, pkt_err=0, bit_cnt=0; sync flops, sh_en_prev, skip counter, shift register = 0.
- Input conditioning:
  - data_in passes through a 2-flop synchronizer to give data_s.
  - Strobe edge: stb = sh_en & ~sh_en_prev, with sh_en_prev registered every cycle. A held-high sh_en counts once.
- States: IDLE, ARMED, SHIFT, DONE (2-bit encoding, in package).
- IDLE:
  - Go to ARMED when RX=1 and fsm_rst=1; clear skip counter, shift register and bit_cnt.
  - Otherwise stay.
- ARMED:
  - Each stb increments the skip counter.
  - When stb arrives with skip counter == SKIP_PULSES, that stb samples the first bit: shift in data_s, bit_cnt=1, go to SHIFT. With SKIP_PULSES=0, the first stb samples.
  - fsm_rst=1 restarts the frame: clear counters, stay ARMED.
- SHIFT:
  - Each stb shifts data_s in (direction per MSB_FIRST) and increments bit_cnt.
  - When the stb brings bit_cnt to PACKET_SIZE, go to DONE.
- DONE (1 cycle):
  - Copy the shift register to pkt_data and pulse pkt_valid=1.
  - Go to IDLE, holding bit_cnt at PACKET_SIZE until the next arm.
- Latency: pkt_valid rises 2 cycles after the cycle in which the final sh_en is high (1 cycle stb register, 1 cycle DONE).
- Abort rules:
  - Applies in ARMED or SHIFT when RX=0, or when sh_en_done rises (0 to 1).
  - Go to IDLE.
  - pkt_err pulses one cycle only if bit_cnt is between 1 and PACKET_SIZE-1 inclusive.
  - pkt_data is not updated.
- Simultaneous events:
  - An abort in the same cycle as stb wins; the bit is dropped.
  - fsm_rst in the same cycle as stb in SHIFT: restart ARMED and drop the bit. This is a new preamble edge.
  - fsm_rst in DONE: no effect; the packet completes.
- Extra strobes after DONE are ignored. The sync FSM emits PACKET_SIZE+1 pulses; with SKIP_PULSES=1 the count matches exactly.
- pkt_valid and pkt_err are never both 1.
- bit_cnt never exceeds PACKET_SIZE.

Optional Feature:
- Macro: SH_RX_PARITY_EN.
- Defined: the last captured bit is even parity over the preceding PACKET_SIZE-1 bits.
  - In DONE, a mismatch asserts pkt_err together with pkt_valid; the payload is still presented. This overrides the exclusivity rule above.
  - Adds output port parity_ok (1 bit, registered at DONE, reset 0).
- Undefined: no parity logic and no parity_ok port; pkt_err is only the abort strobe.

Decomposition:
- Shared package sh_pkg: PACKET_SIZE, PREAMBLE_SIZE, state encodings, and the 1 ms pulse-interval constant (9999) common with the sync FSM.
- One sub-module: sh_bit_sync, the 2-flop synchronizer plus rising-edge detector. It is reused for data_in and for sh_en_done edge detection.

Test Plan:
- Nominal frame: RX=1, fsm_rst pulse, then 25 sh_en pulses 1000 cycles apart, data pattern 0xA5C33C with MSB first after the skipped pulse -> pkt_data=24'hA5C33C, one pkt_valid 2 cycles after the 25th pulse, pkt_err=0.
- Mode abort: RX dropped to 0 after 10 captured bits -> pkt_err single pulse, bit_cnt=10 frozen then cleared on re-arm, pkt_data unchanged.
- Re-preamble: fsm_rst during SHIFT at bit 7 coinciding with sh_en -> bit dropped, state ARMED, next full frame captures correctly with 0 errors.
- Held strobe: sh_en held high 3 cycles -> exactly one bit shifted, bit_cnt increments by 1.
- Async reset mid-SHIFT at bit 12 -> all outputs 0 immediately; after release no pkt_valid without a new fsm_rst.
- SH_RX_PARITY_EN: frame 24'h000003 (even parity OK) -> parity_ok=1, pkt_err=0; frame 24'h000001 -> pkt_valid=1 and pkt_err=1 in the same cycle, parity_ok=0.
